// File: rtl/button_debouncer.sv
// Push-button front end: synchronises rawbtn into uclock, debounces it into
// btnlevel and emits one-cycle press/release strobes on accepted transitions.
module button_debouncer #(
  parameter int unsigned SYNC_STAGES     = 2,
  parameter int unsigned DEBOUNCE_CYCLES = 500000,
  parameter int unsigned CNT_W           = 20
) (
  input  logic uclock,
  input  logic nreset,
  input  logic rawbtn,
  output logic btnlevel,
  output logic btnpress,
  output logic btnrelease
);

  typedef enum logic [1:0] {
    IDLE_LO = 2'd0,
    WAIT_HI = 2'd1,
    IDLE_HI = 2'd2,
    WAIT_LO = 2'd3
  } state_t;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync;
  logic                   s;
  state_t                 state, state_n;
  logic [CNT_W-1:0]       cnt, cnt_n;
  logic                   level_n, press_n, release_n;

  assign s = sync[SYNC_STAGES-1];

  always_ff @(posedge uclock or negedge nreset) begin
    if (!nreset) begin
      sync       <= '0;
      state      <= IDLE_LO;
      cnt        <= '0;
      btnlevel   <= 1'b0;
      btnpress   <= 1'b0;
      btnrelease <= 1'b0;
    end else begin
      sync       <= {sync[SYNC_STAGES-2:0], rawbtn};
      state      <= state_n;
      cnt        <= cnt_n;
      btnlevel   <= level_n;
      btnpress   <= press_n;
      btnrelease <= release_n;
    end
  end

  // Any opposite-level sample in a WAIT state drops back to IDLE, so the
  // next entry restarts the full interval from zero.
  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    level_n   = btnlevel;
    press_n   = 1'b0;
    release_n = 1'b0;
    case (state)
      IDLE_LO: begin
        if (s) begin
          state_n = WAIT_HI;
          cnt_n   = '0;
        end
      end
      WAIT_HI: begin
        if (!s) begin
          state_n = IDLE_LO;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE_HI;
          level_n = 1'b1;
          press_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      IDLE_HI: begin
        if (!s) begin
          state_n = WAIT_LO;
          cnt_n   = '0;
        end
      end
      WAIT_LO: begin
        if (s) begin
          state_n = IDLE_HI;
        end else if (cnt == CNT_LAST) begin
          state_n   = IDLE_LO;
          level_n   = 1'b0;
          release_n = 1'b1;
        end else begin
          cnt_n = cnt + CNT_W'(1);
        end
      end
      default: begin
        state_n = IDLE_LO;
        cnt_n   = '0;
        level_n = 1'b0;
      end
    endcase
  end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with SYNC_STAGES=2, DEBOUNCE_CYCLES=8,
// so an accepted change appears 10 edges after rawbtn is first sampled.
module tb_button_debouncer;

  logic uclock;
  logic nreset;
  logic rawbtn;
  logic btnlevel;
  logic btnpress;
  logic btnrelease;

  int n_cmp;
  int n_err;
  int npress;
  int nrel;
  int nfall;
  logic prev_level;

  int base_p;
  int base_r;
  int base_f;

  button_debouncer #(
    .SYNC_STAGES    (2),
    .DEBOUNCE_CYCLES(8),
    .CNT_W          (4)
  ) dut (
    .uclock    (uclock),
    .nreset    (nreset),
    .rawbtn    (rawbtn),
    .btnlevel  (btnlevel),
    .btnpress  (btnpress),
    .btnrelease(btnrelease)
  );

  initial uclock = 1'b0;
  always #5 uclock = ~uclock;

  // Strobe/edge counters sampled on the falling edge, away from updates.
  initial begin
    npress     = 0;
    nrel       = 0;
    nfall      = 0;
    prev_level = 1'b0;
  end

  always @(negedge uclock) begin
    if (btnpress)   npress = npress + 1;
    if (btnrelease) nrel   = nrel + 1;
    if (prev_level && !btnlevel) nfall = nfall + 1;
    prev_level = btnlevel;
  end

  task automatic check(input string tag, input int got, input int exp);
    n_cmp = n_cmp + 1;
    if (got != exp) begin
      n_err = n_err + 1;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge uclock);
      #1;
    end
  endtask

  task automatic snap();
    base_p = npress;
    base_r = nrel;
    base_f = nfall;
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    nreset = 1'b0;
    rawbtn = 1'b0;

    // Reset state
    ticks(3);
    check("rst_level",   int'(btnlevel),   0);
    check("rst_press",   int'(btnpress),   0);
    check("rst_release", int'(btnrelease), 0);
    nreset = 1'b1;
    ticks(2);

    // Clean press: rawbtn rises before edge k, accepted at edge k+10
    snap();
    rawbtn = 1'b1;
    ticks(10);
    check("clean_k9_level", int'(btnlevel), 0);
    check("clean_k9_press", int'(btnpress), 0);
    ticks(1);
    check("clean_k10_level", int'(btnlevel), 1);
    check("clean_k10_press", int'(btnpress), 1);
    check("clean_k10_rel",   int'(btnrelease), 0);
    ticks(1);
    check("clean_k11_press", int'(btnpress), 0);
    check("clean_k11_level", int'(btnlevel), 1);
    ticks(18);
    check("clean_hold_level",  int'(btnlevel), 1);
    check("clean_press_count", npress - base_p, 1);

    // Asynchronous reset mid-clock with rawbtn high and btnlevel high
    snap();
    #3;
    nreset = 1'b0;
    #1;
    check("async_rst_level",   int'(btnlevel),   0);
    check("async_rst_press",   int'(btnpress),   0);
    check("async_rst_release", int'(btnrelease), 0);
    ticks(2);
    rawbtn = 1'b0;
    ticks(1);
    nreset = 1'b1;
    ticks(12);
    check("post_rst_level", int'(btnlevel), 0);
    check("post_rst_rel",   nrel - base_r,  0);

    // Bouncy press: final rise before edge j, accepted at edge j+10
    snap();
    rawbtn = 1'b1; ticks(5);
    rawbtn = 1'b0; ticks(2);
    rawbtn = 1'b1; ticks(3);
    rawbtn = 1'b0; ticks(1);
    rawbtn = 1'b1;
    ticks(10);
    check("bouncy_j9_level", int'(btnlevel), 0);
    check("bouncy_j9_count", npress - base_p, 0);
    ticks(1);
    check("bouncy_j10_level", int'(btnlevel), 1);
    check("bouncy_j10_press", int'(btnpress), 1);
    ticks(1);
    check("bouncy_j11_press", int'(btnpress), 0);
    check("bouncy_count",     npress - base_p, 1);

    // Release with a 3-cycle low glitch, final fall before edge m
    snap();
    rawbtn = 1'b0; ticks(3);
    rawbtn = 1'b1; ticks(1);
    rawbtn = 1'b0;
    ticks(10);
    check("glitch_m9_level", int'(btnlevel), 1);
    check("glitch_m9_rel",   nrel - base_r,  0);
    ticks(1);
    check("glitch_m10_level", int'(btnlevel),   0);
    check("glitch_m10_rel",   int'(btnrelease), 1);
    check("glitch_m10_press", int'(btnpress),   0);
    ticks(1);
    check("glitch_m11_rel", int'(btnrelease), 0);
    check("glitch_rel_cnt", nrel - base_r,    1);
    check("glitch_prs_cnt", npress - base_p,  0);

    // Reset mid-WAIT_HI: full latency restarts from reset release
    snap();
    rawbtn = 1'b1;
    ticks(6);
    nreset = 1'b0;
    ticks(2);
    check("midwait_rst_level", int'(btnlevel), 0);
    nreset = 1'b1;
    ticks(10);
    check("midwait_r9_level", int'(btnlevel), 0);
    check("midwait_r9_count", npress - base_p, 0);
    ticks(1);
    check("midwait_r10_level", int'(btnlevel), 1);
    check("midwait_r10_press", int'(btnpress), 1);
    ticks(1);
    check("midwait_count", npress - base_p, 1);

    // Return low before the long hold
    rawbtn = 1'b0;
    ticks(15);
    check("prehold_level", int'(btnlevel), 0);

    // Long hold: one press, continuous level, one release
    snap();
    rawbtn = 1'b1;
    ticks(1000);
    check("hold_level",     int'(btnlevel),  1);
    check("hold_press_cnt", npress - base_p, 1);
    check("hold_rel_cnt",   nrel - base_r,   0);
    check("hold_falls",     nfall - base_f,  0);
    rawbtn = 1'b0;
    ticks(20);
    check("hold_end_level", int'(btnlevel),  0);
    check("hold_end_press", npress - base_p, 1);
    check("hold_end_rel",   nrel - base_r,   1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
